// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: default geometry and Gray/binary pointer conversions.
// The conversion functions operate on the widest legal pointer. Callers
// zero-extend into them and size-cast the result back to their own width.
// Leading zeros do not change the low bits of either conversion, so one
// function body serves every ADDR_WIDTH in the legal range.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH_DEFAULT = 3;
  localparam int FIFO_ADDR_WIDTH_MAX     = 12;
  localparam int FIFO_PTR_MAX_W          = FIFO_ADDR_WIDTH_MAX + 1;

  function automatic logic [FIFO_PTR_MAX_W-1:0] bin2gray(
    input logic [FIFO_PTR_MAX_W-1:0] bin
  );
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [FIFO_PTR_MAX_W-1:0] gray2bin(
    input logic [FIFO_PTR_MAX_W-1:0] gray
  );
    logic [FIFO_PTR_MAX_W-1:0] bin;
    bin[FIFO_PTR_MAX_W-1] = gray[FIFO_PTR_MAX_W-1];
    for (int i = FIFO_PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_param_if.sv
// Write-side bundle of the async FIFO: producer request, synchronised read
// pointer, almost-full threshold and overflow clear toward the controller,
// and RAM write port, Gray pointer and status flags back from it.
interface fifo_wr_ctrl_param_if #(
  parameter int ADDR_WIDTH = fifo_pkg::FIFO_ADDR_WIDTH_DEFAULT
);

  logic                  winc;
  logic [ADDR_WIDTH:0]   wq2_rptr;
  logic [ADDR_WIDTH:0]   afull_thresh;
  logic                  ovf_clr;
  logic                  wclken;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr;
  logic                  wfull;
  logic                  walmost_full;
  logic [ADDR_WIDTH:0]   wfill;
  logic                  wovf;

  // Producer / environment side.
  modport master (
    output winc, wq2_rptr, afull_thresh, ovf_clr,
    input  wclken, waddr, wptr, wfull, walmost_full, wfill, wovf
  );

  // Write controller side.
  modport slave (
    input  winc, wq2_rptr, afull_thresh, ovf_clr,
    output wclken, waddr, wptr, wfull, walmost_full, wfill, wovf
  );

endinterface

// File: rtl/fifo_wr_ctrl_param_chk.sv
// Invariant checker for the write controller: the RAM must never be written
// while full, and the reported fill level must never exceed the depth.
module fifo_wr_ctrl_param_chk #(
  parameter int ADDR_WIDTH = fifo_pkg::FIFO_ADDR_WIDTH_DEFAULT
) (
  input logic                W_CLK,
  input logic                W_RST,
  input logic                wclken,
  input logic                wfull,
  input logic [ADDR_WIDTH:0] wfill
);

  localparam int               PTR_W   = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] DEPTH_V = PTR_W'(1 << ADDR_WIDTH);

  a_no_write_when_full: assert property (
    @(posedge W_CLK) disable iff (!W_RST) wclken |-> !wfull
  );

  a_fill_bounded: assert property (
    @(posedge W_CLK) disable iff (!W_RST) wfill <= DEPTH_V
  );

endmodule

// File: rtl/fifo_wr_ctrl_param.sv
// Write-domain controller of the async FIFO. It holds the binary write
// pointer, publishes its Gray form for the read domain, and derives the
// full, almost-full, fill-level and sticky overflow flags from the read
// pointer after that pointer has been synchronised into the write domain.
module fifo_wr_ctrl_param
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEFAULT
) (
  input  logic                W_CLK,
  input  logic                W_RST,
  fifo_wr_ctrl_param_if.slave wr_if
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] wbin_q;
  logic [PTR_W-1:0] wbin_d;
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] wptr_d;
  logic [PTR_W-1:0] wfill_q;
  logic [PTR_W-1:0] wfill_d;
  logic [PTR_W-1:0] rbin_s;
  logic [PTR_W-1:0] full_gray_s;
  logic             wr_en_s;
  logic             wfull_q;
  logic             wfull_d;
  logic             walmost_full_q;
  logic             walmost_full_d;
  logic             wovf_q;
  logic             wovf_d;

  // Next-state: accept/advance, Gray pointer, full/fill/almost-full, overflow.
  always_comb begin
    wr_en_s = wr_if.winc & ~wfull_q;
    wbin_d  = wbin_q + PTR_W'(wr_en_s);
    wptr_d  = PTR_W'(bin2gray(FIFO_PTR_MAX_W'(wbin_d)));
    rbin_s  = PTR_W'(gray2bin(FIFO_PTR_MAX_W'(wr_if.wq2_rptr)));
    // In Gray code, "exactly DEPTH ahead" means the two MSBs are inverted
    // and the other bits are equal.
    full_gray_s = {~wr_if.wq2_rptr[PTR_W-1:PTR_W-2], wr_if.wq2_rptr[PTR_W-3:0]};
    wfull_d     = (wptr_d == full_gray_s);
    // Modular difference. It stays within 0..DEPTH because the writer is
    // blocked when full.
    wfill_d        = wbin_d - rbin_s;
    walmost_full_d = (wfill_d >= wr_if.afull_thresh);
    // A write attempted while full takes priority over a simultaneous clear.
    if (wr_if.winc & wfull_q) begin
      wovf_d = 1'b1;
    end else if (wr_if.ovf_clr) begin
      wovf_d = 1'b0;
    end else begin
      wovf_d = wovf_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wfill_q        <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wovf_q         <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wfill_q        <= wfill_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      wovf_q         <= wovf_d;
    end
  end

  assign wr_if.wclken       = wr_en_s;
  assign wr_if.waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign wr_if.wptr         = wptr_q;
  assign wr_if.wfull        = wfull_q;
  assign wr_if.walmost_full = walmost_full_q;
  assign wr_if.wfill        = wfill_q;
  assign wr_if.wovf         = wovf_q;

endmodule
